prefetch_queue: RTL and testbench

- Parametrised instruction prefetcher for the 80x86 core; merges the prefetch engine and byte FIFO into one block.
- Fetches 16-bit words over the instruction bus into a DEPTH-byte queue, aligning odd IP starts.
- Flushes and redirects on an IP load, including discard of an in-flight access.
- Feeds the decode stages (ModR/M decoder, immediate reader, microcode) one byte per cycle.

---
 rtl/prefetch_pkg.sv | 19 +
 rtl/byte_queue.sv | 74 +++++++
 rtl/prefetch_queue.sv | 108 ++++++++++
 tb/tb_prefetch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared types, reset vector and physical address helper for the prefetcher
package prefetch_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ABORT = 2'd2
    } fetch_state_t;

    localparam logic [15:0] RESET_VECTOR_IP = 16'h0000;

    // Real-mode segment:offset translation; the carry out of bit 19 is dropped.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] ip);
        return {seg, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/byte_queue.sv
// rtl/byte_queue.sv - dual-push/single-pop byte ring with flush; peek port when PREFETCH_PEEK_EN is defined
module byte_queue
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 push_cnt,
    input  byte_t                      push_data0,
    input  byte_t                      push_data1,
    input  logic                       pop,
    output byte_t                      rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PREFETCH_PEEK_EN
    ,
    output byte_t                      rd_data_next,
    output logic                       next_valid
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    byte_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign pop_fire = pop && !empty;
    assign rd_data  = mem[rd_ptr];

`ifdef PREFETCH_PEEK_EN
    assign rd_data_next = mem[ptr_inc(rd_ptr)];
    assign next_valid   = (count >= CW'(2));
`endif

    always_ff @(posedge clk) begin
        if (!flush && push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_data0;
        end
        if (!flush && push_cnt == 2'd2) begin
            mem[ptr_inc(wr_ptr)] <= push_data1;
        end
    end

    // The pop always reads the pre-push head, so a 1-byte queue can pop and refill together.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_cnt == 2'd1) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end else if (push_cnt == 2'd2) begin
                wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
            end
            if (pop_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push_cnt) - CW'(pop_fire);
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - 80x86 instruction prefetcher: fetch FSM, fetch IP and byte queue; PREFETCH_PEEK_EN adds a peek port
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 6,
    parameter logic [15:0] RESET_IP = RESET_VECTOR_IP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                cs,
    input  logic [15:0]                new_ip,
    input  logic                       load_new_ip,
    input  logic                       rd_en,
    output byte_t                      rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       mem_access,
    input  logic                       mem_ack,
    output logic [18:0]                mem_address,
    input  logic [15:0]                mem_data
`ifdef PREFETCH_PEEK_EN
    ,
    output byte_t                      rd_data_next,
    output logic                       next_valid
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t state;
    logic [15:0]  fetch_ip;
    logic [19:0]  phys;
    logic         odd;
    logic         issue_ok;
    logic         accept;
    logic [1:0]   push_cnt;
    byte_t        push_data0;
    byte_t        push_data1;

    assign phys = phys_addr(cs, fetch_ip);
    // The segment base is a multiple of 16, so the physical LSB is the IP parity.
    assign odd  = phys[0];

    assign issue_ok   = (count <= CW'(DEPTH - 2));
    assign accept     = (state == FETCH) && mem_ack && !load_new_ip;
    assign push_cnt   = !accept ? 2'd0 : (odd ? 2'd1 : 2'd2);
    assign push_data0 = odd ? mem_data[15:8] : mem_data[7:0];
    assign push_data1 = mem_data[15:8];
    assign mem_access = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            fetch_ip    <= RESET_IP;
            mem_address <= '0;
        end else if (load_new_ip) begin
            // An access already on the bus must still see its ack before a new one may start.
            fetch_ip <= new_ip;
            case (state)
                FETCH:   state <= mem_ack ? IDLE : ABORT;
                ABORT:   state <= mem_ack ? IDLE : ABORT;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        mem_address <= phys[19:1];
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        fetch_ip <= fetch_ip + (odd ? 16'd1 : 16'd2);
                        state    <= IDLE;
                    end
                end
                ABORT: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    byte_queue #(
        .DEPTH(DEPTH)
    ) u_byte_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (load_new_ip),
        .push_cnt    (push_cnt),
        .push_data0  (push_data0),
        .push_data1  (push_data1),
        .pop         (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count)
`ifdef PREFETCH_PEEK_EN
        ,
        .rd_data_next(rd_data_next),
        .next_valid  (next_valid)
`endif
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - bench for prefetch_queue: directed table, randomized model check, DEPTH=3 streaming
module tb_prefetch_queue;

    localparam int          DEPTH    = 6;
    localparam logic [15:0] RESET_IP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic [2:0]  count;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;

    logic        reset_3;
    logic        rd_en_3;
    logic [7:0]  rd_data_3;
    logic        empty_3;
    logic [1:0]  count_3;
    logic        mem_access_3;
    logic        mem_ack_3;
    logic [18:0] mem_address_3;
    logic [15:0] mem_data_3;

`ifdef PREFETCH_PEEK_EN
    logic [7:0]  rd_data_next;
    logic        next_valid;
    logic [7:0]  rd_data_next_3;
    logic        next_valid_3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prefetch_queue #(.DEPTH(DEPTH), .RESET_IP(RESET_IP)) dut (
        .clk(clk), .reset(reset), .cs(cs), .new_ip(new_ip), .load_new_ip(load_new_ip),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
        .mem_access(mem_access), .mem_ack(mem_ack), .mem_address(mem_address), .mem_data(mem_data)
`ifdef PREFETCH_PEEK_EN
        , .rd_data_next(rd_data_next), .next_valid(next_valid)
`endif
    );

    prefetch_queue #(.DEPTH(3), .RESET_IP(16'h0000)) dut3 (
        .clk(clk), .reset(reset_3), .cs(16'h0000), .new_ip(16'h0000), .load_new_ip(1'b0),
        .rd_en(rd_en_3), .rd_data(rd_data_3), .empty(empty_3), .count(count_3),
        .mem_access(mem_access_3), .mem_ack(mem_ack_3), .mem_address(mem_address_3), .mem_data(mem_data_3)
`ifdef PREFETCH_PEEK_EN
        , .rd_data_next(rd_data_next_3), .next_valid(next_valid_3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst;
        logic [15:0] cs;
        bit          ld;
        logic [15:0] nip;
        bit          rd;
        bit          ack;
        bit          exp_access;
        logic [18:0] exp_addr;
        int          exp_count;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input logic [15:0] c, input bit l, input logic [15:0] n,
                                input bit rd, input bit ack, input bit acc, input logic [18:0] a,
                                input int cnt, input logic [7:0] d);
        vec_t v;
        v.rst = r; v.cs = c; v.ld = l; v.nip = n; v.rd = rd; v.ack = ack;
        v.exp_access = acc; v.exp_addr = a; v.exp_count = cnt; v.exp_rd = d;
        return v;
    endfunction

    // Reference model: a byte queue plus one outstanding bus transaction.
    logic [7:0]  mq[$];
    logic [15:0] m_ip;
    bit          m_busy;
    bit          m_discard;
    logic [18:0] m_addr;

    function automatic logic [18:0] word_of(input logic [15:0] seg, input logic [15:0] ip);
        int unsigned p;
        p = (int'(seg) * 16 + int'(ip)) % (1 << 20);
        return 19'(p / 2);
    endfunction

    task automatic model_step();
        int free;
        if (!reset) begin
            mq.delete();
            m_ip = RESET_IP; m_busy = 0; m_discard = 0; m_addr = '0;
        end else if (load_new_ip) begin
            mq.delete();
            m_ip = new_ip;
            if (m_busy) begin
                if (mem_ack) begin m_busy = 0; m_discard = 0; end
                else m_discard = 1;
            end
        end else begin
            free = DEPTH - mq.size();
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (m_busy) begin
                if (mem_ack) begin
                    if (!m_discard) begin
                        if (m_ip[0]) begin
                            mq.push_back(mem_data[15:8]);
                            m_ip = m_ip + 16'd1;
                        end else begin
                            mq.push_back(mem_data[7:0]);
                            mq.push_back(mem_data[15:8]);
                            m_ip = m_ip + 16'd2;
                        end
                    end
                    m_busy = 0; m_discard = 0;
                end
            end else if (free >= 2) begin
                m_addr = word_of(cs, m_ip);
                m_busy = 1;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_access", 32'(mem_access), 32'(m_busy));
        chk("rnd_addr", 32'(mem_address), 32'(m_addr));
        chk("rnd_count", 32'(count), 32'(mq.size()));
        chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
        if (mq.size() > 0) chk("rnd_rd_data", 32'(rd_data), 32'(mq[0]));
`ifdef PREFETCH_PEEK_EN
        chk("rnd_next_valid", 32'(next_valid), 32'(mq.size() >= 2));
        if (mq.size() >= 2) chk("rnd_rd_data_next", 32'(rd_data_next), 32'(mq[1]));
`endif
    endtask

    initial begin
        int          exp_n;
        logic [7:0]  lo;
        bit          hold;

        reset = 1'b0; cs = 16'hF000; new_ip = '0; load_new_ip = 1'b0; rd_en = 1'b0;
        mem_ack = 1'b0; mem_data = 16'hBBAA;
        reset_3 = 1'b0; rd_en_3 = 1'b0; mem_ack_3 = 1'b0; mem_data_3 = '0;

        // rst, cs, load, new_ip, rd, ack | access, address, count, head
        vecs.push_back(mk(0, 16'hF000, 0, 16'h0000, 0, 0, 0, 19'h00000, 0, 8'h00));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 1, 19'h78000, 0, 8'h00));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 1, 0, 19'h78000, 2, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 1, 19'h78001, 2, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 1, 0, 19'h78001, 4, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 1, 19'h78002, 4, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 1, 0, 19'h78002, 6, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 0, 19'h78002, 6, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 0, 19'h78002, 6, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 1, 0, 0, 19'h78002, 5, 8'hBB));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 1, 0, 0, 19'h78002, 4, 8'hAA));
        vecs.push_back(mk(1, 16'hF000, 0, 16'h0000, 0, 0, 1, 19'h78003, 4, 8'hAA));
        vecs.push_back(mk(1, 16'h0000, 1, 16'h0011, 0, 0, 1, 19'h78003, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 19'h78003, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h00008, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 19'h00008, 1, 8'hBB));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h00009, 1, 8'hBB));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 19'h00009, 3, 8'hBB));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h0000A, 3, 8'hBB));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h0000A, 3, 8'hBB));
        vecs.push_back(mk(1, 16'h0000, 1, 16'h0100, 0, 0, 1, 19'h0000A, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h0000A, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h0000A, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 19'h0000A, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 19'h00080, 0, 8'h00));
        vecs.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 19'h00080, 2, 8'hAA));
        vecs.push_back(mk(1, 16'h1000, 1, 16'hFFFE, 0, 0, 0, 19'h00080, 0, 8'h00));
        vecs.push_back(mk(1, 16'h1000, 0, 16'h0000, 0, 0, 1, 19'h0FFFF, 0, 8'h00));
        vecs.push_back(mk(1, 16'h1000, 0, 16'h0000, 0, 1, 0, 19'h0FFFF, 2, 8'hAA));
        vecs.push_back(mk(1, 16'h1000, 0, 16'h0000, 0, 0, 1, 19'h08000, 2, 8'hAA));
        vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 0, 1, 19'h08000, 2, 8'hAA));
        vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 1, 0, 19'h08000, 4, 8'hAA));
        vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 0, 1, 19'h10001, 4, 8'hAA));
        vecs.push_back(mk(0, 16'h2000, 0, 16'h0000, 0, 0, 0, 19'h00000, 0, 8'h00));
        vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 1, 1, 19'h10000, 0, 8'h00));
        vecs.push_back(mk(1, 16'h2000, 0, 16'h0000, 0, 1, 0, 19'h10000, 2, 8'hAA));

        foreach (vecs[i]) begin
            reset = vecs[i].rst; cs = vecs[i].cs; load_new_ip = vecs[i].ld;
            new_ip = vecs[i].nip; rd_en = vecs[i].rd; mem_ack = vecs[i].ack;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_access", i), 32'(mem_access), 32'(vecs[i].exp_access));
            chk($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_count == 0));
            if (vecs[i].exp_count > 0)
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
`ifdef PREFETCH_PEEK_EN
            chk($sformatf("vec%0d_next_valid", i), 32'(next_valid), 32'(vecs[i].exp_count >= 2));
            if (vecs[i].exp_count >= 2 && vecs[i].exp_rd == 8'hAA)
                chk($sformatf("vec%0d_rd_data_next", i), 32'(rd_data_next), 32'h000000BB);
`endif
        end

        // Randomized run against the reference model.
        reset = 1'b0; load_new_ip = 1'b0; rd_en = 1'b0; mem_ack = 1'b0;
        @(posedge clk); model_step(); #1; model_check();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) != 0);
            load_new_ip = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       new_ip = 16'hFFFE;
                1:       new_ip = 16'hFFFF;
                default: new_ip = 16'($urandom);
            endcase
            if ($urandom_range(0, 29) == 0) cs = 16'($urandom);
            rd_en    = ($urandom_range(0, 2) != 0);
            mem_ack  = mem_access ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            mem_data = 16'($urandom);
            @(posedge clk); model_step(); #1; model_check();
        end
        reset = 1'b1; load_new_ip = 1'b0; rd_en = 1'b0; mem_ack = 1'b0;

        // DEPTH=3 streaming with continuous pops; a hold window drains it to exercise pop-on-empty.
        rd_en_3 = 1'b1; reset_3 = 1'b0;
        @(posedge clk); #1;
        reset_3 = 1'b1;
        exp_n = 0;
        for (int c = 0; c < 90; c++) begin
            hold       = (c >= 40 && c < 50);
            mem_ack_3  = mem_access_3 && !hold;
            lo         = {mem_address_3[6:0], 1'b0};
            mem_data_3 = {lo + 8'd1, lo};
            if (!empty_3) begin
                chk("d3_order", 32'(rd_data_3), 32'(exp_n[7:0]));
                exp_n++;
            end
            @(posedge clk); #1;
            chk("d3_count_max", 32'(count_3 <= 2'd3 && count_3 != 2'd0 || empty_3), 32'd1);
            if (c == 49) begin
                chk("d3_drained_count", 32'(count_3), 32'd0);
                chk("d3_drained_empty", 32'(empty_3), 32'd1);
            end
        end
        chk("d3_progress", 32'(exp_n >= 40), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
